mooreol_param: RTL and testbench
================================

MOOREOL_PARAM -- requirements
Module: mooreol_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b1011: target sequence; bit PAT_W-1 is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port in, input, 1: serial data bit.
REQ-008 SHALL have port in_valid, input, 1: qualifies in; the bit is consumed only when in_valid=1.
REQ-009 SHALL have port clr_cnt, input, 1: synchronous clear of match_cnt.
REQ-010 SHALL have port out, output, 1: Moore match flag.
REQ-011 SHALL have port state_dbg, output, $clog2(PAT_W+1): current state index.
REQ-012 SHALL have port match_cnt, output, CNT_W: number of matches since reset or the last clear.
REQ-013 SHALL have port cnt_sat, output, 1: high while match_cnt equals 2^CNT_W-1.

Function
REQ-014 SHALL hold state s in 0..PAT_W, where s is the length of the longest pattern prefix matching the most recent consumed bits.
REQ-015 For s<PAT_W with in_valid=1, the next state SHALL be s+1 if in==PATTERN[PAT_W-1-s]; otherwise it SHALL be the KMP fallback state (longest proper prefix that is also a suffix of the received bits), computed at elaboration.
REQ-016 For s==PAT_W with in_valid=1: if OVERLAP=1, the next state SHALL follow the transition from fail(PAT_W); if OVERLAP=0, it SHALL follow the transition from state 0.
REQ-017 With in_valid=0, s, out and match_cnt SHALL hold (clr_cnt still acts).
REQ-018 out SHALL be registered and equal (s==PAT_W): high in the cycle after the edge that consumed the final pattern bit, for exactly one consumed bit per match.
REQ-019 Back-to-back matches (e.g. PATTERN all ones, OVERLAP=1) SHALL keep out high continuously, with one count per match.
REQ-020 match_cnt SHALL increment on every edge where s enters PAT_W (including PAT_W->PAT_W), and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-021 clr_cnt with a simultaneous match SHALL set match_cnt to 1; clr_cnt without a match SHALL set it to 0; clr_cnt SHALL NOT affect s or out.
REQ-022 state_dbg SHALL equal s.
REQ-023 Illegal PAT_W or CNT_W values SHALL cause an elaboration error.

Reset
REQ-024 rst=1 at a clock edge SHALL force s=0, out=0, match_cnt=0 and cnt_sat=0, overriding in_valid and clr_cnt.
REQ-025 A reset applied mid-pattern SHALL discard the partial match; detection SHALL restart from the first bit after rst deasserts.

Structure
REQ-026 Package mooreol_pkg SHALL hold the state-index width function and the elaboration-time fallback (failure) table function.
REQ-027 The saturating match counter SHALL be a sub-module, mooreol_sat_cnt (parameter CNT_W; ports inc, clr, cnt, sat).

Verification
REQ-028 Defaults, OVERLAP=1, valid stream 1011011 -> out pulses 2 times (after bits 4 and 7); match_cnt=2.
REQ-029 OVERLAP=0, same stream 1011011 -> exactly 1 pulse (after bit 4); match_cnt=1.
REQ-030 PATTERN=4'b1111, OVERLAP=1, six ones -> out high for 3 consecutive cycles; match_cnt=3. With OVERLAP=0 -> 1 match.
REQ-031 Bits 1,0,(in_valid=0 for 3 cycles, in toggling),1,1 -> exactly one match; s holds at 2 during the gap.
REQ-032 Bits 1,0,1 then rst for one cycle, then 1 -> no match; state_dbg=1; all outputs 0 during reset.
REQ-033 CNT_W=2, 5 matches -> match_cnt=3, cnt_sat=1; then clr_cnt coincident with a match -> match_cnt=1, cnt_sat=0.

Source files
------------

// File: rtl/mooreol_pkg.sv
// Shared helpers for the mooreol sequence detector: state-index width and
// elaboration-time KMP failure / transition tables.
package mooreol_pkg;

    localparam int MAX_PAT_W = 16;
    localparam int MAX_SW    = 5;

    // One entry per state 0..MAX_PAT_W, wide enough for any state index.
    typedef logic [MAX_PAT_W:0][MAX_SW-1:0] state_tab_t;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Bit j of the pattern in arrival order (j = 0 is the first bit received).
    function automatic logic pat_bit(input logic [15:0] pattern, input int pat_w, input int j);
        int idx;
        idx = pat_w - 1 - j;
        if (idx < 0 || idx > 15) return 1'b0;
        return pattern[idx];
    endfunction

    // f[k] = longest proper prefix of the first k pattern bits that is also a suffix.
    function automatic state_tab_t fail_table(input logic [15:0] pattern, input int pat_w);
        state_tab_t f;
        int k;
        f = '0;
        for (int i = 1; i < MAX_PAT_W; i++) begin
            if (i < pat_w) begin
                k = int'(f[i]);
                for (int it = 0; it < MAX_PAT_W; it++) begin
                    if (k > 0 && pat_bit(pattern, pat_w, k) != pat_bit(pattern, pat_w, i))
                        k = int'(f[k]);
                end
                if (pat_bit(pattern, pat_w, k) == pat_bit(pattern, pat_w, i))
                    k = k + 1;
                f[i+1] = k[MAX_SW-1:0];
            end
        end
        return f;
    endfunction

    // Next state for every current state when bit b is consumed.
    function automatic state_tab_t next_table(input logic [15:0] pattern, input int pat_w,
                                              input logic overlap, input logic b);
        state_tab_t f;
        state_tab_t nt;
        int k;
        int nxt;
        logic done;
        f  = fail_table(pattern, pat_w);
        nt = '0;
        for (int s = 0; s <= MAX_PAT_W; s++) begin
            if (s <= pat_w) begin
                // A full match restarts from scratch when overlapping is disabled.
                k    = (s == pat_w && !overlap) ? 0 : s;
                nxt  = 0;
                done = 1'b0;
                for (int it = 0; it <= MAX_PAT_W + 1; it++) begin
                    if (!done) begin
                        if (k < pat_w && pat_bit(pattern, pat_w, k) == b) begin
                            nxt  = k + 1;
                            done = 1'b1;
                        end else if (k == 0) begin
                            done = 1'b1;
                        end else begin
                            k = int'(f[k]);
                        end
                    end
                end
                nt[s] = nxt[MAX_SW-1:0];
            end
        end
        return nt;
    endfunction

endpackage

// File: rtl/mooreol_sat_cnt.sv
// Saturating match counter; a clear coinciding with an increment loads 1.
module mooreol_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("mooreol_sat_cnt: CNT_W must be in 1..32");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = CNT_W'(inc);
        else if (inc && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mooreol_param.sv
// Parameterised Moore serial pattern detector (KMP automaton) with a
// saturating match counter.
module mooreol_param
    import mooreol_pkg::*;
#(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in,
    input  logic                       in_valid,
    input  logic                       clr_cnt,
    output logic                       out,
    output logic [$clog2(PAT_W+1)-1:0] state_dbg,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat
);

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $error("mooreol_param: PAT_W must be in 2..16");
    end

    localparam int               SW     = state_w(PAT_W);
    localparam logic [SW-1:0]    S_FULL = SW'(PAT_W);
    localparam state_tab_t       NEXT0  = next_table(16'(PATTERN), PAT_W, OVERLAP != 0, 1'b0);
    localparam state_tab_t       NEXT1  = next_table(16'(PATTERN), PAT_W, OVERLAP != 0, 1'b1);

    logic [SW-1:0] s_q;
    logic [SW-1:0] s_d;
    logic          out_q;
    logic          out_d;
    logic          match;

    always_comb begin
        s_d   = s_q;
        match = 1'b0;
        if (in_valid) begin
            s_d   = in ? NEXT1[s_q][SW-1:0] : NEXT0[s_q][SW-1:0];
            match = (s_d == S_FULL);
        end
        out_d = (s_d == S_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            out_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            out_q <= out_d;
        end
    end

    mooreol_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (clr_cnt),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

    assign out       = out_q;
    assign state_dbg = s_q;

endmodule

// File: tb/tb_mooreol_param.sv
// Bench for mooreol_param: six configurations share one stimulus stream and are
// compared against a history-based reference model after every clock.
module tb_mooreol_param;

    localparam int NI = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_b = 1'b0;
    logic in_v = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    logic        out_obs [NI];
    logic        sat_obs [NI];
    logic [7:0]  st_obs  [NI];
    logic [31:0] cnt_obs [NI];

    logic [2:0] st0, st1, st2, st3, st4;
    logic [1:0] st5;
    logic [7:0] c0, c1;
    logic [1:0] c2, c3;
    logic [2:0] c4;
    logic [0:0] c5;

    mooreol_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(in_v), .clr_cnt(clr),
        .out(out_obs[0]), .state_dbg(st0), .match_cnt(c0), .cnt_sat(sat_obs[0]));
    mooreol_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(in_v), .clr_cnt(clr),
        .out(out_obs[1]), .state_dbg(st1), .match_cnt(c1), .cnt_sat(sat_obs[1]));
    mooreol_param #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(in_v), .clr_cnt(clr),
        .out(out_obs[2]), .state_dbg(st2), .match_cnt(c2), .cnt_sat(sat_obs[2]));
    mooreol_param #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(0), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(in_v), .clr_cnt(clr),
        .out(out_obs[3]), .state_dbg(st3), .match_cnt(c3), .cnt_sat(sat_obs[3]));
    mooreol_param #(.PAT_W(5), .PATTERN(5'b10101), .OVERLAP(1), .CNT_W(3)) u4 (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(in_v), .clr_cnt(clr),
        .out(out_obs[4]), .state_dbg(st4), .match_cnt(c4), .cnt_sat(sat_obs[4]));
    mooreol_param #(.PAT_W(2), .PATTERN(2'b01), .OVERLAP(0), .CNT_W(1)) u5 (
        .clk(clk), .rst(rst), .in(in_b), .in_valid(in_v), .clr_cnt(clr),
        .out(out_obs[5]), .state_dbg(st5), .match_cnt(c5), .cnt_sat(sat_obs[5]));

    assign st_obs[0] = 8'(st0);
    assign st_obs[1] = 8'(st1);
    assign st_obs[2] = 8'(st2);
    assign st_obs[3] = 8'(st3);
    assign st_obs[4] = 8'(st4);
    assign st_obs[5] = 8'(st5);
    assign cnt_obs[0] = 32'(c0);
    assign cnt_obs[1] = 32'(c1);
    assign cnt_obs[2] = 32'(c2);
    assign cnt_obs[3] = 32'(c3);
    assign cnt_obs[4] = 32'(c4);
    assign cnt_obs[5] = 32'(c5);

    // Configuration of each instance, as seen by the reference model.
    int          pw_c   [NI] = '{4, 4, 4, 4, 5, 2};
    logic [15:0] pat_c  [NI] = '{16'hB, 16'hB, 16'hF, 16'hF, 16'h15, 16'h1};
    bit          ov_c   [NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int          cmax_c [NI] = '{255, 255, 3, 3, 7, 1};

    // Model state: recent bits (bit 0 newest), usable bit count, prefix length, count.
    logic [31:0] hist  [NI];
    int          avail [NI];
    int          ms    [NI];
    int          mc    [NI];

    int tests = 0;
    int fails = 0;

    // Longest pattern prefix equal to the most recent bits, limited to usable bits.
    function automatic int longest_prefix(input logic [31:0] h, input int av,
                                          input logic [15:0] p, input int w);
        bit ok;
        for (int k = w; k >= 1; k--) begin
            if (k <= av) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (h[k-1-j] !== p[w-1-j]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic model_step(input logic b, input logic v, input logic c, input logic r);
        bit match;
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                hist[i]  = '0;
                avail[i] = 0;
                ms[i]    = 0;
                mc[i]    = 0;
            end else begin
                match = 1'b0;
                if (v) begin
                    if (!ov_c[i] && ms[i] == pw_c[i]) avail[i] = 0;
                    hist[i] = {hist[i][30:0], b};
                    if (avail[i] < 32) avail[i]++;
                    ms[i] = longest_prefix(hist[i], avail[i], pat_c[i], pw_c[i]);
                    match = (ms[i] == pw_c[i]);
                end
                if (c)
                    mc[i] = match ? 1 : 0;
                else if (match && mc[i] < cmax_c[i])
                    mc[i]++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d_out", i), 32'(out_obs[i]), 32'(ms[i] == pw_c[i]));
            chk($sformatf("u%0d_state", i), 32'(st_obs[i]), 32'(ms[i]));
            chk($sformatf("u%0d_cnt", i), cnt_obs[i], 32'(mc[i]));
            chk($sformatf("u%0d_sat", i), 32'(sat_obs[i]), 32'(mc[i] == cmax_c[i]));
        end
    endtask

    task automatic step(input logic b, input logic v, input logic c, input logic r);
        in_b = b;
        in_v = v;
        clr  = c;
        rst  = r;
        @(posedge clk);
        #1;
        model_step(b, v, c, r);
        check_all();
    endtask

    logic [6:0] s1011011;
    int run_len;

    initial begin
        // Reset state.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < NI; i++) begin
            chk("rst_out", 32'(out_obs[i]), 32'd0);
            chk("rst_cnt", cnt_obs[i], 32'd0);
        end

        // Stream 1011011: two overlapping matches, one non-overlapping.
        s1011011 = 7'b1011011;
        for (int k = 6; k >= 0; k--) step(s1011011[k], 1'b1, 1'b0, 1'b0);
        chk("ovl_cnt", cnt_obs[0], 32'd2);
        chk("novl_cnt", cnt_obs[1], 32'd1);

        // Six ones on the all-ones pattern: out stays high for three cycles.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        run_len = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (out_obs[2]) run_len++;
        end
        chk("ones_run", 32'(run_len), 32'd3);
        chk("ones_ovl_cnt", cnt_obs[2], 32'd3);
        chk("ones_novl_cnt", cnt_obs[3], 32'd1);

        // Valid gap mid-pattern: state holds while in toggles.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(k[0], 1'b0, 1'b0, 1'b0);
            chk("gap_state", 32'(st_obs[0]), 32'd2);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("gap_cnt", cnt_obs[0], 32'd1);

        // Reset mid-pattern discards the partial match.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("midrst_state", 32'(st_obs[0]), 32'd0);
        chk("midrst_out", 32'(out_obs[0]), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("after_rst_state", 32'(st_obs[0]), 32'd1);
        chk("after_rst_cnt", cnt_obs[0], 32'd0);

        // Saturation on a 2-bit counter, then clear coinciding with a match.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", cnt_obs[2], 32'd3);
        chk("sat_flag", 32'(sat_obs[2]), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_match_cnt", cnt_obs[2], 32'd1);
        chk("clr_match_sat", 32'(sat_obs[2]), 32'd0);
        chk("clr_keeps_out", 32'(out_obs[2]), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_nomatch_cnt", cnt_obs[2], 32'd0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
